// File: rtl/seq_identifier.sv
// seq_identifier: identifies which of eight mod-256 generator sequences produced an 8-bit sample stream
module seq_identifier #(
  parameter int MIN_SAMPLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_valid,
  input  logic [7:0] sample,
  input  logic       clear,
  output logic [7:0] match_mask,
  output logic [2:0] seq_id,
  output logic       locked,
  output logic       no_match,
  output logic [7:0] sample_count
);
  logic [7:0] sq_n, sq_sq, e3, tr_t, tr_k, fb_a, fb_b, pl_a, pl_b;
  logic [7:0] lc_a, lc_b, pd_a, pd_b, pd_c, sy_a, sy_b;
  logic [7:0] hits, next_mask;
  logic       restart;
  assign restart   = reset | clear;
  assign sq_sq     = sq_n * sq_n;
  assign hits      = {sample == sy_a, sample == pd_a, sample == lc_a, sample == pl_a,
                      sample == fb_a, sample == tr_t, sample == e3, sample == sq_sq};
  assign next_mask = match_mask & hits;
  assign locked    = (match_mask != 8'd0) && ((match_mask & (match_mask - 8'd1)) == 8'd0) &&
                     (sample_count >= 8'(MIN_SAMPLES));
  // seq_id picks the lowest surviving candidate, 0 when none survive
  always_comb begin
    seq_id = 3'd0;
    for (int i = 7; i >= 0; i--) if (match_mask[i]) seq_id = 3'(i);
  end
  // all reference models step on every accepted sample, eliminated or not
  always_ff @(posedge clk) begin
    if (restart) begin
      sq_n <= 8'd0;
      e3   <= 8'd1;
      tr_t <= 8'd0;
      tr_k <= 8'd1;
      fb_a <= 8'd1;
      fb_b <= 8'd1;
      pl_a <= 8'd0;
      pl_b <= 8'd1;
      lc_a <= 8'd2;
      lc_b <= 8'd1;
      pd_a <= 8'd1;
      pd_b <= 8'd1;
      pd_c <= 8'd1;
      sy_a <= 8'd2;
      sy_b <= 8'd3;
    end else if (sample_valid) begin
      sq_n <= sq_n + 8'd1;
      e3   <= e3 + e3 + e3;
      tr_t <= tr_t + tr_k;
      tr_k <= tr_k + 8'd1;
      fb_a <= fb_b;
      fb_b <= fb_a + fb_b;
      pl_a <= pl_b;
      pl_b <= pl_b + pl_b + pl_a;
      lc_a <= lc_b;
      lc_b <= lc_a + lc_b;
      pd_a <= pd_b;
      pd_b <= pd_c;
      pd_c <= pd_a + pd_b;
      sy_a <= sy_b;
      sy_b <= sy_b * (sy_b - 8'd1) + 8'd1;
    end
  end
  // candidate elimination, sticky no-match and saturating sample counter
  always_ff @(posedge clk) begin
    if (restart) begin
      match_mask   <= 8'hFF;
      no_match     <= 1'b0;
      sample_count <= 8'd0;
    end else if (sample_valid) begin
      match_mask   <= next_mask;
      no_match     <= no_match | (next_mask == 8'd0);
      sample_count <= sample_count + {7'd0, sample_count != 8'hFF};
    end
  end
endmodule

// File: tb/tb_seq_identifier.sv
// tb_seq_identifier: randomized and directed checks of seq_identifier against a sequence-term model
module tb_seq_identifier;
  logic       clk = 1'b0, reset = 1'b1, sample_valid = 1'b0, clear = 1'b0;
  logic [7:0] sample = 8'd0;
  logic [7:0] match_mask, sample_count;
  logic [2:0] seq_id;
  logic       locked, no_match;
  int         checks = 0, passes = 0;
  int         cnt = 0;
  logic [7:0] mm = 8'hFF;

  seq_identifier #(.MIN_SAMPLES(4)) dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample(sample), .clear(clear),
    .match_mask(match_mask), .seq_id(seq_id), .locked(locked), .no_match(no_match),
    .sample_count(sample_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] term(input int s, input int n);
    int a, b, c, t;
    case (s)
      0: a = (n * n) % 256;
      1: begin a = 1; repeat (n) a = (a * 3) % 256; end
      2: a = (n * (n + 1) / 2) % 256;
      3: begin a = 1; b = 1; repeat (n) begin t = (a + b) % 256; a = b; b = t; end end
      4: begin a = 0; b = 1; repeat (n) begin t = (2 * b + a) % 256; a = b; b = t; end end
      5: begin a = 2; b = 1; repeat (n) begin t = (a + b) % 256; a = b; b = t; end end
      6: begin a = 1; b = 1; c = 1; repeat (n) begin t = (a + b) % 256; a = b; b = c; c = t; end end
      default: begin a = 2; b = 3; repeat (n) begin t = (b * (b - 1) + 1) % 256; a = b; b = t; end end
    endcase
    return a[7:0];
  endfunction

  function automatic logic [2:0] exp_id();
    for (int i = 0; i < 8; i++) if (mm[i]) return 3'(i);
    return 3'd0;
  endfunction

  function automatic logic exp_locked();
    return ($countones(mm) == 1) && (cnt >= 4);
  endfunction

  function automatic logic [7:0] exp_count();
    return (cnt > 255) ? 8'd255 : 8'(cnt);
  endfunction

  task automatic send(input logic [7:0] v);
    @(negedge clk);
    sample_valid = 1'b1;
    sample = v;
    @(posedge clk);
    #1 sample_valid = 1'b0;
    for (int i = 0; i < 8; i++) if (mm[i] && v != term(i, cnt)) mm[i] = 1'b0;
    cnt++;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic restart(input bit use_clear, input logic [7:0] v);
    @(negedge clk);
    reset = !use_clear;
    clear = use_clear;
    sample_valid = 1'b1;
    sample = v;
    @(posedge clk);
    #1 reset = 1'b0;
    clear = 1'b0;
    sample_valid = 1'b0;
    cnt = 0;
    mm = 8'hFF;
  endtask

  task automatic test_reset();
    sample_valid = 1'b1;
    sample = 8'h00;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    sample_valid = 1'b0;
    checks++; if (match_mask !== 8'hFF) $display("FAIL reset_mask got %h want ff", match_mask); else passes++;
    checks++; if (seq_id !== 3'd0) $display("FAIL reset_id got %0d want 0", seq_id); else passes++;
    checks++; if (locked !== 1'b0) $display("FAIL reset_locked got %b want 0", locked); else passes++;
    checks++; if (no_match !== 1'b0) $display("FAIL reset_nomatch got %b want 0", no_match); else passes++;
    checks++; if (sample_count !== 8'd0) $display("FAIL reset_count got %0d want 0", sample_count); else passes++;
  endtask

  task automatic test_squares();
    logic [7:0] v[4] = '{0, 1, 4, 9};
    logic [7:0] m[4] = '{8'h15, 8'h15, 8'h01, 8'h01};
    restart(1'b0, 8'd0);
    for (int i = 0; i < 4; i++) begin
      send(v[i]);
      checks++; if (match_mask !== m[i]) $display("FAIL sq_mask[%0d] got %h want %h", i, match_mask, m[i]); else passes++;
      checks++; if (locked !== (i == 3)) $display("FAIL sq_locked[%0d] got %b want %b", i, locked, i == 3); else passes++;
    end
    checks++; if (seq_id !== 3'd0) $display("FAIL sq_id got %0d want 0", seq_id); else passes++;
    checks++; if (sample_count !== 8'd4) $display("FAIL sq_count got %0d want 4", sample_count); else passes++;
  endtask

  task automatic test_fib_gaps();
    logic [7:0] v[4] = '{1, 1, 2, 3};
    logic [7:0] m[4] = '{8'h4A, 8'h48, 8'h08, 8'h08};
    for (int g = 0; g <= 3; g += 3) begin
      restart(1'b1, 8'd1);
      for (int i = 0; i < 4; i++) begin
        send(v[i]);
        idle(g);
        checks++; if (match_mask !== m[i]) $display("FAIL fib_mask[g%0d,%0d] got %h want %h", g, i, match_mask, m[i]); else passes++;
        checks++; if (sample_count !== 8'(i + 1)) $display("FAIL fib_count[g%0d,%0d] got %0d want %0d", g, i, sample_count, i + 1); else passes++;
      end
      checks++; if (locked !== 1'b1) $display("FAIL fib_locked[g%0d] got %b want 1", g, locked); else passes++;
      checks++; if (seq_id !== 3'd3) $display("FAIL fib_id[g%0d] got %0d want 3", g, seq_id); else passes++;
    end
  endtask

  task automatic test_sylv();
    logic [7:0] v[6] = '{2, 3, 7, 43, 15, 211};
    restart(1'b0, 8'd2);
    for (int i = 0; i < 6; i++) begin
      send(v[i]);
      checks++; if (match_mask !== ((i == 0) ? 8'hA0 : 8'h80)) $display("FAIL sylv_mask[%0d] got %h want %h", i, match_mask, (i == 0) ? 8'hA0 : 8'h80); else passes++;
      checks++; if (locked !== (i >= 3)) $display("FAIL sylv_locked[%0d] got %b want %b", i, locked, i >= 3); else passes++;
    end
    checks++; if (seq_id !== 3'd7) $display("FAIL sylv_id got %0d want 7", seq_id); else passes++;
  endtask

  task automatic test_exp3();
    logic [7:0] v[7] = '{1, 3, 9, 27, 81, 243, 217};
    restart(1'b1, 8'd0);
    for (int i = 0; i < 7; i++) begin
      send(v[i]);
      checks++; if (locked !== (i >= 3)) $display("FAIL exp3_locked[%0d] got %b want %b", i, locked, i >= 3); else passes++;
    end
    checks++; if (seq_id !== 3'd1) $display("FAIL exp3_id got %0d want 1", seq_id); else passes++;
    checks++; if (match_mask !== 8'h02) $display("FAIL exp3_mask got %h want 02", match_mask); else passes++;
  endtask

  task automatic test_mismatch();
    restart(1'b0, 8'd0);
    send(8'd0);
    send(8'd1);
    checks++; if (match_mask !== 8'h15) $display("FAIL mis_mask2 got %h want 15", match_mask); else passes++;
    checks++; if (no_match !== 1'b0) $display("FAIL mis_nomatch2 got %b want 0", no_match); else passes++;
    send(8'd5);
    checks++; if (match_mask !== 8'h00) $display("FAIL mis_mask3 got %h want 00", match_mask); else passes++;
    checks++; if (no_match !== 1'b1) $display("FAIL mis_nomatch3 got %b want 1", no_match); else passes++;
    checks++; if (locked !== 1'b0) $display("FAIL mis_locked3 got %b want 0", locked); else passes++;
    checks++; if (seq_id !== 3'd0) $display("FAIL mis_id3 got %0d want 0", seq_id); else passes++;
    send(8'd16);
    send(8'($urandom));
    checks++; if (sample_count !== 8'd5) $display("FAIL mis_count got %0d want 5", sample_count); else passes++;
    checks++; if (no_match !== 1'b1) $display("FAIL mis_sticky got %b want 1", no_match); else passes++;
    checks++; if (match_mask !== 8'h00) $display("FAIL mis_mask5 got %h want 00", match_mask); else passes++;
  endtask

  task automatic test_clear();
    logic [7:0] luc[4] = '{2, 1, 3, 4};
    logic [7:0] tri_v[4] = '{0, 1, 3, 6};
    for (int r = 0; r < 2; r++) begin
      restart(r == 1, 8'd0);
      for (int i = 0; i < 4; i++) send(luc[i]);
      checks++; if (locked !== 1'b1 || seq_id !== 3'd5) $display("FAIL clr_luc[%0d] got locked %b id %0d want 1 5", r, locked, seq_id); else passes++;
      restart(r == 0, 8'd7);
      checks++; if (match_mask !== 8'hFF) $display("FAIL clr_mask[%0d] got %h want ff", r, match_mask); else passes++;
      checks++; if (sample_count !== 8'd0) $display("FAIL clr_count[%0d] got %0d want 0", r, sample_count); else passes++;
      checks++; if (no_match !== 1'b0 || locked !== 1'b0) $display("FAIL clr_flags[%0d] got nm %b lk %b want 0 0", r, no_match, locked); else passes++;
      for (int i = 0; i < 4; i++) send(tri_v[i]);
      checks++; if (locked !== 1'b1 || seq_id !== 3'd2) $display("FAIL clr_tri[%0d] got locked %b id %0d want 1 2", r, locked, seq_id); else passes++;
      checks++; if (match_mask !== 8'h04) $display("FAIL clr_trimask[%0d] got %h want 04", r, match_mask); else passes++;
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      int s, len;
      s = $urandom_range(7);
      len = $urandom_range(12, 1);
      restart($urandom_range(1) == 1, 8'($urandom));
      for (int i = 0; i < len; i++) begin
        send(($urandom_range(7) == 0) ? 8'($urandom) : term(s, cnt));
        idle($urandom_range(2));
        checks++; if (match_mask !== mm) $display("FAIL rnd_mask[%0d,%0d] got %h want %h", t, i, match_mask, mm); else passes++;
        checks++; if (seq_id !== exp_id()) $display("FAIL rnd_id[%0d,%0d] got %0d want %0d", t, i, seq_id, exp_id()); else passes++;
        checks++; if (locked !== exp_locked()) $display("FAIL rnd_locked[%0d,%0d] got %b want %b", t, i, locked, exp_locked()); else passes++;
        checks++; if (no_match !== (mm == 8'd0)) $display("FAIL rnd_nomatch[%0d,%0d] got %b want %b", t, i, no_match, mm == 8'd0); else passes++;
        checks++; if (sample_count !== exp_count()) $display("FAIL rnd_count[%0d,%0d] got %0d want %0d", t, i, sample_count, exp_count()); else passes++;
      end
    end
  endtask

  task automatic test_back_to_back();
    int s;
    s = $urandom_range(7);
    restart(1'b0, 8'd0);
    for (int i = 0; i < 300; i++) begin
      send(term(s, cnt));
      if (i == 253 || i == 254 || i == 299) begin
        checks++; if (sample_count !== exp_count()) $display("FAIL sat_count[%0d] got %0d want %0d", i, sample_count, exp_count()); else passes++;
      end
    end
    checks++; if (match_mask !== mm) $display("FAIL sat_mask got %h want %h", match_mask, mm); else passes++;
    checks++; if (locked !== exp_locked()) $display("FAIL sat_locked got %b want %b", locked, exp_locked()); else passes++;
    checks++; if (seq_id !== exp_id()) $display("FAIL sat_id got %0d want %0d", seq_id, exp_id()); else passes++;
    send(term(s, cnt) + 8'd1);
    checks++; if (match_mask !== mm) $display("FAIL sat_elim got %h want %h", match_mask, mm); else passes++;
    checks++; if (sample_count !== 8'd255) $display("FAIL sat_hold got %0d want 255", sample_count); else passes++;
  endtask

  initial begin
    test_reset();
    test_squares();
    test_fib_gaps();
    test_sylv();
    test_exp3();
    test_mismatch();
    test_clear();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
